calc_seq_alu: RTL

Parametrised successor to the single-shot table adder. It accepts a token stream of the form operand, op, operand, ... , EQUAL over a valid/ready handshake. It keeps a running accumulator, supports chained add/sub, and flags signed/unsigned overflow. Results go out on a valid/ready output port with backpressure. It sits between the keypad/token decoder and the display/result consumer.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_alu.sv | 39 +++
 rtl/calc_seq_alu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator.
// Op codes, token kinds and FSM state encoding.
package calc_pkg;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_EQUAL = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic KIND_OPND = 1'b0;
    localparam logic KIND_OP   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_OP,
        ST_WAIT_OPND,
        ST_OUT
    } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational add/sub with carry/borrow or
// two's-complement overflow detection.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] ext;

    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
        sum = ext[W-1:0];
        if (SIGNED != 0) begin
            // sub: a - b overflows when signs differ and result leaves a's sign
            if (sub) begin
                ovf = (a[W-1] != b[W-1]) &&
                      (sum[W-1] != a[W-1]);
            end else begin
                ovf = (a[W-1] == b[W-1]) &&
                      (sum[W-1] != a[W-1]);
            end
        end else begin
            ovf = ext[W];
        end
    end

endmodule

// File: rtl/calc_seq_alu.sv
// Token-driven accumulator calculator with valid/ready
// input and a backpressured result port.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int W      = 8,
    parameter int SIGNED = 0,
    parameter int CHAIN  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_kind,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_ovf,
    output logic         err
);

    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] res_q, res_d;
    logic         rovf_q, rovf_d;
    logic         err_q, err_d;

    logic         take;
    logic         is_op;
    logic [1:0]   op;
    logic [W-1:0] alu_sum;
    logic         alu_ovf;

    assign in_ready   = (state_q != ST_OUT);
    assign out_valid  = (state_q == ST_OUT);
    assign out_result = res_q;
    assign out_ovf    = rovf_q;
    assign err        = err_q;

    assign take  = in_valid && in_ready;
    assign is_op = (in_kind == KIND_OP);
    assign op    = in_data[1:0];

    calc_alu #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_alu (
        .a   (acc_q),
        .b   (in_data),
        .sub (op_q == OP_SUB),
        .sum (alu_sum),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        op_d    = op_q;
        res_d   = res_q;
        rovf_d  = rovf_q;
        err_d   = 1'b0;
        if (take && is_op && (op == OP_CLEAR)) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        if (!is_op) begin
                            acc_d   = in_data;
                            ovf_d   = 1'b0;
                            state_d = ST_WAIT_OP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_WAIT_OP: begin
                    if (take) begin
                        if (!is_op) begin
                            err_d = 1'b1;
                        end else if (op == OP_EQUAL) begin
                            res_d   = acc_q;
                            rovf_d  = ovf_q;
                            state_d = ST_OUT;
                        end else begin
                            op_d    = op;
                            state_d = ST_WAIT_OPND;
                        end
                    end
                end
                ST_WAIT_OPND: begin
                    if (take) begin
                        if (!is_op) begin
                            acc_d   = alu_sum;
                            ovf_d   = ovf_q | alu_ovf;
                            state_d = ST_WAIT_OP;
                        end else if (op == OP_EQUAL) begin
                            err_d = 1'b1;
                        end else begin
                            op_d = op;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (CHAIN != 0) begin
                            // continue from the result as a new first operand
                            acc_d   = res_q;
                            ovf_d   = 1'b0;
                            state_d = ST_WAIT_OP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            rovf_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rovf_q  <= rovf_d;
            err_q   <= err_d;
        end
    end

endmodule
